// File: rtl/intr_ctrl_pkg.sv
// Shared interrupt-controller constants, source bit assignments and the status vector type.
package intr_ctrl_pkg;

   localparam int INTR_NUM_SRC  = 4;
   localparam int INTR_PULSE_W  = 1;

   localparam int INTR_BLIT     = 1;
   localparam int INTR_VIDEO_LO = 2;
   localparam int INTR_VIDEO_HI = 3;

   typedef logic [INTR_NUM_SRC-1:0] intr_vec_t;

   // A single source still needs a one-bit id port.
   function automatic int intr_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Interrupt source/control bundle between the system (master) and intr_ctrl (slave).
interface intr_ctrl_if
   import intr_ctrl_pkg::*;
#(
   parameter int NUM_SRC = INTR_NUM_SRC
) ();

   localparam int ID_W = intr_id_w(NUM_SRC);

   // No handshake: every field is level-valid each cycle; clear/force are one-cycle strobes.
   logic [NUM_SRC-1:0] intr_signal_i;
   logic [NUM_SRC-1:0] intr_mask_i;
   logic [NUM_SRC-1:0] intr_clear_i;
   logic [NUM_SRC-1:0] intr_force_i;
   logic [NUM_SRC-1:0] intr_status_o;
   logic [NUM_SRC-1:0] intr_pending_o;
   logic               intr_any_o;
   logic [ID_W-1:0]    intr_id_o;
   logic               bus_intr_o;

   modport master (
      output intr_signal_i, intr_mask_i, intr_clear_i, intr_force_i,
      input  intr_status_o, intr_pending_o, intr_any_o, intr_id_o, bus_intr_o
   );

   modport slave (
      input  intr_signal_i, intr_mask_i, intr_clear_i, intr_force_i,
      output intr_status_o, intr_pending_o, intr_any_o, intr_id_o, bus_intr_o
   );

endinterface

// File: rtl/intr_ctrl_pulse_gen.sv
// intr_pulse_gen: loadable down-counter that stretches a one-cycle load into a PULSE_W-cycle pulse.
module intr_pulse_gen #(
   parameter int PULSE_W = 1
) (
   input  logic clk,
   input  logic reset_n_i,
   input  logic load_i,
   output logic pulse_o
);

   localparam int CW = $clog2(PULSE_W + 1);

   logic [CW-1:0] cnt_q;
   logic          pulse_q;

   // Output is registered: high the cycle after a load, or while the count has more than one left.
   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= load_i | (cnt_q > CW'(1));
         if (load_i) begin
            cnt_q <= CW'(PULSE_W);
         end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge/level capture into sticky status, mask gating, priority id and bus pulse.
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int                 NUM_SRC    = INTR_NUM_SRC,
   parameter int                 PULSE_W    = INTR_PULSE_W,
   parameter logic [NUM_SRC-1:0] LEVEL_MASK = '0
) (
   input  logic       clk,
   input  logic       reset_n_i,
   intr_ctrl_if.slave intr
);

   localparam int ID_W = intr_id_w(NUM_SRC);

   logic [NUM_SRC-1:0] sig_q;
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] status_q;
   logic [NUM_SRC-1:0] status_d;
   logic [NUM_SRC-1:0] event_v;
   logic [NUM_SRC-1:0] pending;
   logic [ID_W-1:0]    id;
   logic               trigger;

   always_comb begin
      event_v  = (intr.intr_signal_i & LEVEL_MASK)
               | (intr.intr_signal_i & ~sig_q & ~LEVEL_MASK)
               | intr.intr_force_i;
      // Set wins over clear, so a coincident event is never lost.
      status_d = (status_q & ~intr.intr_clear_i) | event_v;
      pending  = status_q & intr.intr_mask_i;
      trigger  = (|(event_v & intr.intr_mask_i & ~status_q))
               | (|(intr.intr_mask_i & ~mask_q & status_q));
   end

   always_comb begin
      id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending[i]) id = ID_W'(i);
      end
   end

   // sig_q tracks the input during reset so a source held high across release is not an edge.
   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         sig_q    <= intr.intr_signal_i;
         mask_q   <= '0;
         status_q <= '0;
      end else begin
         sig_q    <= intr.intr_signal_i;
         mask_q   <= intr.intr_mask_i;
         status_q <= status_d;
      end
   end

   intr_pulse_gen #(
      .PULSE_W (PULSE_W)
   ) u_pulse (
      .clk       (clk),
      .reset_n_i (reset_n_i),
      .load_i    (trigger),
      .pulse_o   (intr.bus_intr_o)
   );

   assign intr.intr_status_o  = status_q;
   assign intr.intr_pending_o = pending;
   assign intr.intr_any_o     = |pending;
   assign intr.intr_id_o      = id;

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter: NUM_SRC, default 4, number of interrupt sources; legal range 1-16.
REQ-002 Parameter: PULSE_W, default 1, number of cycles bus_intr_o stays high per trigger; legal range 1-255.
REQ-003 Parameter: LEVEL_MASK, default 0, NUM_SRC-bit mask; bit=1 makes the source level-sensitive, bit=0 makes it rising-edge-sensitive.
REQ-004 Port: clk, input, 1, pixel clock; all logic is clocked on its rising edge.
REQ-005 Port: reset_n_i, input, 1, reset; synchronous and active-low.
REQ-006 Port: intr_signal_i, input, NUM_SRC, raw interrupt sources (video, blit, copper, ...).
REQ-007 Port: intr_mask_i, input, NUM_SRC, per-source enable (SYS_CTRL).
REQ-008 Port: intr_clear_i, input, NUM_SRC, CPU clear strobe, one cycle per bit.
REQ-009 Port: intr_force_i, input, NUM_SRC, CPU software-set strobe.
REQ-010 Port: intr_status_o, output, NUM_SRC, latched status, independent of mask.
REQ-011 Port: intr_pending_o, output, NUM_SRC, intr_status_o AND intr_mask_i (combinational).
REQ-012 Port: intr_any_o, output, 1, OR-reduction of intr_pending_o.
REQ-013 Port: intr_id_o, output, max(1,clog2(NUM_SRC)), lowest-index pending bit; 0 when none pending.
REQ-014 Port: bus_intr_o, output, 1, registered CPU interrupt pulse.

Function
REQ-015 The module SHALL register intr_signal_i each cycle into sig_q.
REQ-016 event[i] SHALL be intr_signal_i[i] when LEVEL_MASK[i]=1, otherwise intr_signal_i[i] AND NOT sig_q[i], in both cases ORed with intr_force_i[i].
REQ-017 The status register SHALL update as: status <= (status AND NOT intr_clear_i) OR event.
REQ-018 When event and clear coincide on one bit, the set SHALL win and the event SHALL NOT be lost.
REQ-019 A level source held high SHALL re-set its status bit on the cycle after a clear.
REQ-020 Status SHALL latch regardless of the mask; the mask gates only pending, any, id and bus_intr_o.
REQ-021 trigger SHALL be true when (event AND intr_mask_i AND NOT status) is nonzero.
REQ-022 trigger SHALL also be true when a mask bit rises (mask_q=0, mask=1) while that status bit is 1; this requires a registered mask_q.
REQ-023 On trigger in cycle n, the pulse counter SHALL load PULSE_W, and bus_intr_o SHALL be high in cycles n+1 through n+PULSE_W.
REQ-024 A trigger while the pulse is active SHALL reload the counter (retrigger extends the pulse; there are no gaps and no count wrap).
REQ-025 The counter width SHALL be clog2(PULSE_W+1), and it SHALL saturate at 0.
REQ-026 Latency SHALL be: input edge at cycle n gives status, pending and id valid at n+1, and bus_intr_o high at n+1.
REQ-027 Clearing a status bit SHALL NOT truncate an active bus_intr_o pulse.
REQ-028 intr_id_o SHALL use fixed priority, with index 0 the highest.

Reset
REQ-029 While reset_n_i=0 at a clock edge: status=0, counter=0, bus_intr_o=0, mask_q=0.
REQ-030 While reset_n_i=0 at a clock edge, sig_q SHALL load intr_signal_i, so a source held high across reset release produces no spurious edge event.
REQ-031 Reset asserted mid-pulse SHALL drop bus_intr_o on the next edge, and inputs SHALL be ignored while reset is asserted.

Structure
REQ-032 The xv package SHALL hold the typedef intr_vec_t (NUM_SRC bits), the constants INTR_NUM_SRC=4 and INTR_PULSE_W, and the source bit indices (INTR_BLIT=1, video bits 3:2).
REQ-033 The block SHALL use one sub-module, intr_pulse_gen, a loadable down-counter pulse stretcher parameterised by PULSE_W.
REQ-034 xosera_main SHALL instantiate intr_ctrl in place of its inline interrupt logic.

Verification
REQ-035 NUM_SRC=4, PULSE_W=1, mask=0010, rising edge on bit1 -> status=0010, pending=0010, id=1, one-cycle bus_intr_o at n+1.
REQ-036 Same configuration, bit1 edge while status[1]=1 -> no bus_intr_o; clear[1] plus new edge in the same cycle -> status[1] stays 1.
REQ-037 PULSE_W=4, trigger at n and again at n+2 -> bus_intr_o high n+1 through n+6 continuously.
REQ-038 mask=0000, edge on bit3 -> status=1000, bus_intr_o=0; then mask=1000 -> bus_intr_o pulse the next cycle, id=3.
REQ-039 LEVEL_MASK=0001, bit0 held high, clear[0] -> status[0] stays 1 the following cycle; release, clear -> status[0]=0.
REQ-040 intr_signal_i=1111 held through reset release -> status=0000 and no pulse; force=0100 -> status=0100, pulse if mask[2]=1.
